hier_node_dispatch: RTL and testbench
=====================================

# hier_node_dispatch

Parametrised hierarchy node that replaces the fixed five-child tree nodes with a configurable fan-out stage. It buffers work tokens from its parent, dispatches each to one of NUM_CHILD child instances in round-robin order over valid/ready handshakes, and tracks per-child outstanding work via completion pulses. It sits at every internal level of the module tree and reports aggregate idle and protocol-error status upward.

## Interface
- NUM_CHILD, 5, number of child channels (2..16)
- DATA_W, 8, token payload width
- DEPTH, 4, input FIFO depth (power of two, ≥2)
- MAX_OUT, 3, maximum outstanding tokens per child (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  parent token valid
- in_ready  out  1  FIFO not full
- in_data  in  DATA_W  token payload
- ch_valid  out  NUM_CHILD  per-child valid, at most one-hot in unicast
- ch_ready  in  NUM_CHILD  per-child ready
- ch_data  out  DATA_W  shared payload bus (FIFO head)
- ch_done  in  NUM_CHILD  per-child completion pulse, one token each
- idle  out  1  FIFO empty and all outstanding counters zero
- err_done  out  1  sticky: done seen on child with zero outstanding

## Operation
- Input FIFO, DEPTH entries; push on in_valid && in_ready; in_ready = !full.
- Eligible child i: ch_ready[i] && out_cnt[i] < MAX_OUT.
- Grant: first eligible child scanning from rr_ptr upward, wrapping at NUM_CHILD-1 → 0. ch_valid[grant] = 1 only when FIFO non-empty and a child is eligible; ch_data = head entry.
- Transfer on ch_valid[i] && ch_ready[i]: pop FIFO, out_cnt[i] += 1, rr_ptr ← (i+1) mod NUM_CHILD.
- ch_done[i]: out_cnt[i] -= 1. Same-cycle transfer and done on one child: count unchanged. Done with out_cnt[i] == 0: count stays 0, err_done set until reset.
- No eligible child: head holds, ch_valid all zero, rr_ptr unchanged.
- Counter width $clog2(MAX_OUT+1); never exceeds MAX_OUT.

## Timing
- Reset values: in_ready 1, ch_valid 0, ch_data 0, idle 1, err_done 0; FIFO empty, rr_ptr 0, all out_cnt 0. Reset mid-operation discards buffered and outstanding state immediately.
- Latency: token pushed at edge k is on ch_data/ch_valid from cycle k+1; one dispatch per cycle maximum.
- Full FIFO with simultaneous push and pop: in_ready is 0, so push refused; pop proceeds.
- Empty FIFO: push at edge k, earliest pop at edge k+1 (no bypass).
- idle and err_done registered-state derived, combinational from state, no input paths.

## Configuration
- HIER_NODE_DISPATCH_BROADCAST_EN defined: extra port in_bcast (in, 1) stored per FIFO entry. A broadcast head waits until all NUM_CHILD children are eligible in the same cycle, then asserts all ch_valid bits; transfer completes only when every ch_ready is high that cycle; all counters increment; rr_ptr unchanged.
- Not defined: in_bcast absent, FIFO entry is DATA_W bits, unicast only.

## Structure
- Package hier_node_pkg: token struct (data, bcast), counter width function, default parameter constants.
- Sub-module hier_node_fifo: synchronous FIFO with full/empty, parametrised width/depth; dispatch, arbitration and counters in top.

## Test plan
- Reset, then 5 tokens 0x10..0x14, all children ready (NUM_CHILD=5) → dispatched to children 0,1,2,3,4 on consecutive cycles, each out_cnt = 1, idle 0.
- ch_ready[1]=0, tokens 0xA0,0xA1 with rr_ptr=1 → 0xA0 to child 2, 0xA1 to child 3.
- Child 0 receives 3 tokens without done (MAX_OUT=3), 4th token → skips child 0; done on child 0 → eligible again next cycle.
- All ch_ready=0, push 4 tokens → in_ready drops to 0 after 4th; 5th in_valid not accepted.
- ch_done[2] pulse with out_cnt[2]=0 → err_done = 1, stays 1 until rst; counters unchanged.
- Broadcast build: in_bcast token 0x55 with child 4 not ready → no ch_valid; child 4 ready → all five ch_valid high one cycle, all out_cnt +1.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared types and defaults for the hierarchy dispatch node.
// The token struct describes a FIFO entry at the default payload width.
package hier_node_pkg;

  localparam int NUM_CHILD_DEF = 5;
  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int MAX_OUT_DEF   = 3;

  typedef struct packed {
    logic                  bcast;
    logic [DATA_W_DEF-1:0] data;
  } token_t;

  // Width of a counter able to hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/hier_node_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one wrap bit.
// There is no push-to-pop bypass, so a new entry is visible one cycle after the push.
module hier_node_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/hier_node_dispatch.sv
// Fan-out hierarchy node: buffers parent tokens and deals them round-robin to children.
// Optional broadcast tokens are enabled by defining HIER_NODE_DISPATCH_BROADCAST_EN.
module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
  input  logic                 in_bcast,
`endif
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_CHILD-1:0] ch_valid,
  input  logic [NUM_CHILD-1:0] ch_ready,
  output logic [DATA_W-1:0]    ch_data,
  input  logic [NUM_CHILD-1:0] ch_done,
  output logic                 idle,
  output logic                 err_done
);

  localparam int CW = cnt_width(MAX_OUT);
  localparam int PW = $clog2(NUM_CHILD);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CHILD - 1);
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif

  logic [FW-1:0]        fifo_wdata, fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop, head_bcast;
  logic [CW-1:0]        cnt_q [NUM_CHILD];
  logic [CW-1:0]        cnt_d [NUM_CHILD];
  logic [PW-1:0]        rr_q, rr_d;
  logic                 err_q, err_d;
  logic [NUM_CHILD-1:0] elig, xfer;
  logic [PW-1:0]        grant_idx;
  logic                 grant_found;
  logic                 any_out;

`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
  assign fifo_wdata = {in_bcast, in_data};
  assign head_bcast = fifo_rdata[DATA_W];
`else
  assign fifo_wdata = in_data;
  assign head_bcast = 1'b0;
`endif

  assign in_ready = !fifo_full;
  assign ch_data  = fifo_rdata[DATA_W-1:0];

  hier_node_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && in_ready),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    for (int i = 0; i < NUM_CHILD; i++) elig[i] = ch_ready[i] && (cnt_q[i] < MAX_CNT);
  end

  // Round-robin scan starting at rr_q, wrapping past the last child.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CHILD) idx = idx - NUM_CHILD;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  // Handshake: a child accepts the head token on the cycle where its
  // ch_valid and ch_ready are both high. ch_valid is only raised towards
  // eligible (ready, under-limit) children and never depends on ch_done.
  always_comb begin
    ch_valid = '0;
    if (!fifo_empty) begin
      if (head_bcast) begin
        if (&elig) ch_valid = '1;
      end else if (grant_found) begin
        ch_valid[grant_idx] = 1'b1;
      end
    end
  end

  assign xfer     = ch_valid & ch_ready;
  assign fifo_pop = |xfer;

  always_comb begin
    rr_d = rr_q;
    if (fifo_pop && !head_bcast) rr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_ONE;
  end

  // A done arriving with nothing outstanding is flagged and otherwise ignored.
  always_comb begin
    err_d   = err_q;
    any_out = 1'b0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) any_out = 1'b1;
      if (ch_done[i] && cnt_q[i] == '0) err_d = 1'b1;
      if (xfer[i] && !ch_done[i]) cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (!xfer[i] && ch_done[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
  end

  assign idle     = fifo_empty && !any_out;
  assign err_done = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_CHILD; i++) cnt_q[i] <= '0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_CHILD; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Directed bench for hier_node_dispatch against a queue-based model of the node.
module tb_hier_node_dispatch;

  localparam int N     = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXO  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [N-1:0]  ch_valid, ch_ready, ch_done;
  logic [DW-1:0] ch_data;
  logic          idle, err_done;
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
  logic          in_bcast;
`endif

  int errors = 0;
  int checks = 0;

  // model state: token queue {bcast,data}, per-child outstanding, pointer, sticky error
  logic [8:0]  m_q[$];
  int          m_cnt [N];
  int          m_rr;
  logic        m_err;
  logic [15:0] exp_q[$];

  logic [N-1:0] ev;
  int           g;
  logic [8:0]   head;
  logic         push_ok, bc_in;

  hier_node_dispatch #(.NUM_CHILD(N), .DATA_W(DW), .DEPTH(DEPTH), .MAX_OUT(MAXO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_ready (in_ready),
    .in_data  (in_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .ch_data  (ch_data),
    .ch_done  (ch_done),
    .idle     (idle),
    .err_done (err_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_disp(input string name, input int ch, input int d);
    logic [15:0] v;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no dispatch expected %0h", name, {ch[7:0], d[7:0]});
    end else begin
      v = exp_q.pop_front();
      check(name, {16'h0, v}, {16'h0, ch[7:0], d[7:0]});
    end
  endtask

  // Compare on the falling edge, then advance the model by the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr  = 0;
      m_err = 1'b0;
      check("rst_in_ready", {31'h0, in_ready}, 1);
      check("rst_ch_valid", {27'h0, ch_valid}, 0);
      check("rst_ch_data", {24'h0, ch_data}, 0);
      check("rst_idle", {31'h0, idle}, 1);
      check("rst_err_done", {31'h0, err_done}, 0);
    end else begin
      ev   = '0;
      g    = -1;
      head = '0;
      if (m_q.size() > 0) begin
        head = m_q[0];
        if (head[8]) begin
          ev = '1;
          for (int i = 0; i < N; i++)
            if (!(ch_ready[i] && m_cnt[i] < MAXO)) ev = '0;
        end else begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (g < 0 && ch_ready[c] && m_cnt[c] < MAXO) g = c;
          end
          if (g >= 0) ev[g] = 1'b1;
        end
      end
      check("cmp_in_ready", {31'h0, in_ready}, {31'h0, m_q.size() < DEPTH});
      check("cmp_ch_valid", {27'h0, ch_valid}, {27'h0, ev});
      if (m_q.size() > 0) check("cmp_ch_data", {24'h0, ch_data}, {24'h0, head[7:0]});
      check("cmp_idle", {31'h0, idle}, {31'h0, (m_q.size() == 0) && (m_cnt.sum() == 0)});
      check("cmp_err_done", {31'h0, err_done}, {31'h0, m_err});

      push_ok = in_valid && (m_q.size() < DEPTH);
      for (int i = 0; i < N; i++) begin
        if (ch_done[i] && m_cnt[i] == 0) m_err = 1'b1;
        if (ev[i] && !ch_done[i]) m_cnt[i] = m_cnt[i] + 1;
        else if (!ev[i] && ch_done[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
      if (ev != '0) begin
        void'(m_q.pop_front());
        if (head[8]) exp_q.push_back({8'hFF, head[7:0]});
        else begin
          exp_q.push_back({8'(g), head[7:0]});
          m_rr = (g + 1) % N;
        end
      end
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
      bc_in = in_bcast;
`else
      bc_in = 1'b0;
`endif
      if (push_ok) m_q.push_back({bc_in, in_data});
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_ready = '0; ch_done = '0;
`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
    in_bcast = 1'b0;
`endif
    step(2);
    check("lit_rst_in_ready", {31'h0, in_ready}, 1);
    check("lit_rst_idle", {31'h0, idle}, 1);
    rst = 1'b0;
    step(1);

    // five tokens round-robin over all children
    ch_ready = '1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i); step(1);
    end
    in_valid = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      expect_disp("t1_disp", i, 8'h10 + i);
      check("t1_cnt", m_cnt[i], 1);
    end
    check("t1_idle", {31'h0, idle}, 0);
    ch_done = '1; step(1); ch_done = '0; step(1);
    check("t1_idle_after_done", {31'h0, idle}, 1);

    // child 1 not ready, pointer at 1
    in_valid = 1'b1; in_data = 8'h20; step(1); in_valid = 1'b0; step(1);
    expect_disp("t2_disp_20", 0, 8'h20);
    ch_ready = 5'b11101;
    in_valid = 1'b1; in_data = 8'hA0; step(1);
    in_data = 8'hA1; step(1);
    in_valid = 1'b0; step(2);
    expect_disp("t2_disp_a0", 2, 8'hA0);
    expect_disp("t2_disp_a1", 3, 8'hA1);
    ch_done = 5'b01101; step(1); ch_done = '0; step(1);

    // child 0 saturates at MAX_OUT, then frees a slot
    ch_ready = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i); step(1);
    end
    in_valid = 1'b0;
    check("t3_held_valid", {27'h0, ch_valid}, 0);
    step(1);
    check("t3_held_valid2", {27'h0, ch_valid}, 0);
    check("t3_cnt0_max", m_cnt[0], 3);
    ch_done = 5'b00001; step(1); ch_done = '0;
    check("t3_release_valid", {27'h0, ch_valid}, 32'h1);
    check("t3_release_data", {24'h0, ch_data}, 32'h33);
    step(1);
    for (int i = 0; i < 4; i++) expect_disp("t3_disp", 0, 8'h30 + i);
    ch_done = 5'b00001; step(3); ch_done = '0; step(1);
    check("t3_cnt0_zero", m_cnt[0], 0);
    check("t3_idle", {31'h0, idle}, 1);

    // fill the FIFO with no child ready; full push refused, then drain
    ch_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i); step(1);
    end
    check("t4_full_in_ready", {31'h0, in_ready}, 0);
    in_data = 8'h44; step(1);
    check("t4_refused_size", m_q.size(), 4);
    check("t4_still_full", {31'h0, in_ready}, 0);
    ch_ready = '1; step(1);
    step(1);
    in_valid = 1'b0; step(5);
    expect_disp("t4_disp_40", 1, 8'h40);
    expect_disp("t4_disp_41", 2, 8'h41);
    expect_disp("t4_disp_42", 3, 8'h42);
    expect_disp("t4_disp_43", 4, 8'h43);
    expect_disp("t4_disp_44", 0, 8'h44);
    check("t4_no_extra", exp_q.size(), 0);
    ch_done = '1; step(1); ch_done = '0; step(1);

    // done on an idle child sets the sticky error
    check("t5_err_before", {31'h0, err_done}, 0);
    ch_done = 5'b00100; step(1); ch_done = '0;
    check("t5_err_set", {31'h0, err_done}, 1);
    check("t5_cnt2", m_cnt[2], 0);
    step(3);
    check("t5_err_sticky", {31'h0, err_done}, 1);
    check("t5_idle", {31'h0, idle}, 1);

    // reset in the middle of work
    ch_ready = '0;
    in_valid = 1'b1; in_data = 8'h60; step(1); in_data = 8'h61; step(1); in_valid = 1'b0;
    check("t5_busy", {31'h0, idle}, 0);
    rst = 1'b1; #1;
    check("t5_rst_idle", {31'h0, idle}, 1);
    check("t5_rst_err", {31'h0, err_done}, 0);
    step(1);
    rst = 1'b0; step(1);

`ifdef HIER_NODE_DISPATCH_BROADCAST_EN
    ch_ready = 5'b01111;
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h55; step(1);
    in_valid = 1'b0; in_bcast = 1'b0;
    check("t6_bc_wait", {27'h0, ch_valid}, 0);
    step(1);
    check("t6_bc_wait2", {27'h0, ch_valid}, 0);
    ch_ready = '1; #1;
    check("t6_bc_valid", {27'h0, ch_valid}, 32'h1F);
    check("t6_bc_data", {24'h0, ch_data}, 32'h55);
    step(1);
    check("t6_bc_after", {27'h0, ch_valid}, 0);
    for (int i = 0; i < N; i++) check("t6_bc_cnt", m_cnt[i], 1);
    expect_disp("t6_bc_disp", 255, 8'h55);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
